// File: rtl/lzrw1_group_packer_if.sv
// ---------------------------------------------------------------------------
// lzrw1_group_packer_if
//   Bundles the token input handshake, the packed byte output handshake and
//   the flush/status signals of lzrw1_group_packer.
//
//   Handshake rule (both directions): a beat transfers on a rising clock edge
//   where valid && ready are both high; while valid is high and ready is low
//   the sender holds every payload field stable.
//
//   Modports:
//     slave  - the packer side (consumes tokens, produces bytes)
//     master - the surrounding logic (match stage upstream, writer downstream)
//
//   Signals:
//     in_valid / in_ready        token handshake
//     in_is_copy                 1 = copy token, 0 = literal
//     in_length, in_offset       copy fields
//     in_literal                 literal byte
//     done                       end-of-input request (flush partial group)
//     out_valid / out_ready      packed byte handshake
//     out_data                   packed byte
//     out_last                   final byte of a flushed stream
//     flush_done                 one-cycle flush completion pulse
//     byte_count                 bytes delivered since reset
// ---------------------------------------------------------------------------
interface lzrw1_group_packer_if #(
    parameter int LEN_W = 4,
    parameter int OFF_W = 12,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_is_copy;
    logic [LEN_W-1:0] in_length;
    logic [OFF_W-1:0] in_offset;
    logic [7:0]       in_literal;
    logic             done;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             flush_done;
    logic [CNT_W-1:0] byte_count;

    modport slave (
        input  in_valid, in_is_copy, in_length, in_offset, in_literal, done, out_ready,
        output in_ready, out_valid, out_data, out_last, flush_done, byte_count
    );

    modport master (
        output in_valid, in_is_copy, in_length, in_offset, in_literal, done, out_ready,
        input  in_ready, out_valid, out_data, out_last, flush_done, byte_count
    );
endinterface

// File: rtl/lzrw1_group_packer.sv
// ---------------------------------------------------------------------------
// lzrw1_group_packer
//   Packs literal/copy tokens into LZRW1 groups: GROUP_ITEMS/8 control bytes
//   (least-significant first, bit i = 1 when item i is a copy) followed by
//   the item bytes in acceptance order (literal: 1 byte; copy: 2 bytes,
//   {length, offset[hi]} then offset[7:0]). The packed stream leaves one
//   byte per cycle.
//
//   Ports:
//     clock        rising-edge clock
//     reset        synchronous, active-high
//     bus          lzrw1_group_packer_if.slave (token in, bytes out, status)
//     o_dbg_state  current FSM state (FILL/EMIT_CTRL/EMIT_DATA/FLUSH_ACK)
//
//   Interface widths must match LEN_W/OFF_W/CNT_W; LEN_W+OFF_W must be 16
//   so that a copy occupies exactly two bytes.
//
//   The buffer is a single bank: tokens are accepted only in FILL, so
//   input and output never overlap.
// ---------------------------------------------------------------------------
module lzrw1_group_packer #(
    parameter int GROUP_ITEMS = 16,
    parameter int LEN_W       = 4,
    parameter int OFF_W       = 12,
    parameter int CNT_W       = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    lzrw1_group_packer_if.slave       bus,
    output logic [1:0]                o_dbg_state
);
    localparam int CTRL_BYTES = GROUP_ITEMS / 8;
    localparam int BUF_BYTES  = 2 * GROUP_ITEMS;
    localparam int IDX_W      = $clog2(BUF_BYTES);
    localparam int PTR_W      = $clog2(BUF_BYTES + 1);
    localparam int ITM_W      = $clog2(GROUP_ITEMS + 1);

    localparam logic [1:0] S_FILL      = 2'd0;
    localparam logic [1:0] S_EMIT_CTRL = 2'd1;
    localparam logic [1:0] S_EMIT_DATA = 2'd2;
    localparam logic [1:0] S_FLUSH_ACK = 2'd3;

    localparam logic [ITM_W-1:0] ITEMS_FULL = ITM_W'(GROUP_ITEMS);
    localparam logic [PTR_W-1:0] CTRL_LAST  = PTR_W'(CTRL_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO    = PTR_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]             r_state;
    logic [ITM_W-1:0]       r_items;
    logic [GROUP_ITEMS-1:0] r_ctrl;
    logic [7:0]             r_buf [BUF_BYTES];
    logic [PTR_W-1:0]       r_wr_ptr;     // bytes stored in the current group
    logic [PTR_W-1:0]       r_rd_idx;     // control byte index, then data byte index
    logic                   r_final;      // current group ends the stream
    logic                   r_flush_pend; // done arrived while emitting
    logic [CNT_W-1:0]       r_byte_count;

    logic                   w_accept;
    logic                   w_out_valid;
    logic                   w_xfer;
    logic                   w_done_eff;
    logic [ITM_W-1:0]       w_items_next;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [PTR_W-1:0]       w_wr_ptr1;
    logic                   w_data_last;
    logic [7:0]             w_byte0;
    logic [7:0]             w_byte1;
    logic [7:0]             w_ctrl_byte;
    logic [7:0]             w_out_data;

    assign w_accept     = (r_state == S_FILL) && bus.in_valid;
    assign w_out_valid  = (r_state == S_EMIT_CTRL) || (r_state == S_EMIT_DATA);
    assign w_xfer       = w_out_valid && bus.out_ready;
    assign w_done_eff   = bus.done || r_flush_pend;
    assign w_items_next = r_items + ITM_W'(w_accept);
    assign w_wr_ptr1    = r_wr_ptr + PTR_ONE;
    assign w_ptr_next   = r_wr_ptr + (bus.in_is_copy ? PTR_TWO : PTR_ONE);
    assign w_data_last  = (r_rd_idx == (r_wr_ptr - PTR_ONE));
    assign w_byte0      = {bus.in_length, bus.in_offset[OFF_W-1:8]};
    assign w_byte1      = bus.in_offset[7:0];

    always_comb begin
        w_ctrl_byte = '0;
        for (int i = 0; i < CTRL_BYTES; i++) begin
            if (r_rd_idx == PTR_W'(i)) begin
                w_ctrl_byte = r_ctrl[i*8 +: 8];
            end
        end
        w_out_data = '0;
        case (r_state)
            S_EMIT_CTRL: w_out_data = w_ctrl_byte;
            S_EMIT_DATA: w_out_data = r_buf[r_rd_idx[IDX_W-1:0]];
            default:     w_out_data = '0;
        endcase
    end

    // Item storage carries no reset: its contents are only read below r_wr_ptr.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            if (bus.in_is_copy) begin
                r_buf[r_wr_ptr[IDX_W-1:0]]  <= w_byte0;
                r_buf[w_wr_ptr1[IDX_W-1:0]] <= w_byte1;
            end else begin
                r_buf[r_wr_ptr[IDX_W-1:0]]  <= bus.in_literal;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_items      <= '0;
            r_ctrl       <= '0;
            r_wr_ptr     <= '0;
            r_rd_idx     <= '0;
            r_final      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_byte_count <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < GROUP_ITEMS; i++) begin
                            if (r_items == ITM_W'(i)) begin
                                r_ctrl[i] <= bus.in_is_copy;
                            end
                        end
                        r_items  <= w_items_next;
                        r_wr_ptr <= w_ptr_next;
                    end
                    // A token accepted together with done belongs to the flushed group.
                    if (w_items_next == ITEMS_FULL) begin
                        r_state  <= S_EMIT_CTRL;
                        r_final  <= w_done_eff;
                        r_rd_idx <= '0;
                    end else if (w_done_eff) begin
                        if (w_items_next != '0) begin
                            r_state  <= S_EMIT_CTRL;
                            r_final  <= 1'b1;
                            r_rd_idx <= '0;
                        end else begin
                            r_state <= S_FLUSH_ACK;
                        end
                    end
                end
                S_EMIT_CTRL: begin
                    if (bus.done) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_rd_idx == CTRL_LAST) begin
                            r_rd_idx <= '0;
                            r_state  <= S_EMIT_DATA;
                        end else begin
                            r_rd_idx <= r_rd_idx + PTR_ONE;
                        end
                    end
                end
                S_EMIT_DATA: begin
                    if (bus.done) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_data_last) begin
                            r_items  <= '0;
                            r_ctrl   <= '0;
                            r_wr_ptr <= '0;
                            r_rd_idx <= '0;
                            r_state  <= r_final ? S_FLUSH_ACK : S_FILL;
                        end else begin
                            r_rd_idx <= r_rd_idx + PTR_ONE;
                        end
                    end
                end
                default: begin
                    r_flush_pend <= 1'b0;
                    r_final      <= 1'b0;
                    r_state      <= S_FILL;
                end
            endcase
            if (w_xfer) begin
                r_byte_count <= r_byte_count + CNT_ONE;
            end
        end
    end

    assign bus.in_ready   = (r_state == S_FILL);
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_data;
    assign bus.out_last   = (r_state == S_EMIT_DATA) && r_final && w_data_last;
    assign bus.flush_done = (r_state == S_FLUSH_ACK);
    assign bus.byte_count = r_byte_count;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_lzrw1_group_packer.sv
module tb_lzrw1_group_packer;
  localparam int G = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lzrw1_group_packer_if #(.LEN_W(4), .OFF_W(12), .CNT_W(32)) bus ();
  logic [1:0] dbg_state;

  lzrw1_group_packer #(.GROUP_ITEMS(G), .LEN_W(4), .OFF_W(12), .CNT_W(32)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        is_copy;
    logic [3:0]  len;
    logic [11:0] off;
    logic [7:0]  lit;
  } tok_t;

  tok_t       grp_q[$];
  logic [7:0] exp_q[$];
  bit         exp_final;
  int         model_bytes;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Builds the expected packed bytes of the buffered group from the token list.
  function automatic void close_group(input bit fin);
    longint ctrl = 0;
    int     v;
    foreach (grp_q[i]) if (grp_q[i].is_copy) ctrl = ctrl | (longint'(1) << i);
    for (int k = 0; k < G / 8; k++) exp_q.push_back(8'((ctrl >> (8 * k)) & 255));
    foreach (grp_q[i]) begin
      if (grp_q[i].is_copy) begin
        v = (int'(grp_q[i].len) * 16) + (int'(grp_q[i].off) / 256);
        exp_q.push_back(8'(v));
        exp_q.push_back(8'(int'(grp_q[i].off) % 256));
      end else begin
        exp_q.push_back(grp_q[i].lit);
      end
    end
    grp_q.delete();
    exp_final = fin;
  endfunction

  function automatic tok_t lit_tok(input logic [7:0] b);
    tok_t t;
    t = '0;
    t.lit = b;
    return t;
  endfunction

  function automatic tok_t copy_tok(input logic [3:0] l, input logic [11:0] o);
    tok_t t;
    t = '0;
    t.is_copy = 1'b1;
    t.len = l;
    t.off = o;
    return t;
  endfunction

  function automatic tok_t rand_tok();
    tok_t t;
    t.is_copy = 1'($urandom_range(0, 1));
    t.len     = 4'($urandom_range(0, 15));
    t.off     = 12'($urandom_range(0, 4095));
    t.lit     = 8'($urandom_range(0, 255));
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_is_copy = 1'b0;
    bus.in_length  = '0;
    bus.in_offset  = '0;
    bus.in_literal = '0;
    bus.done       = 1'b0;
  endtask

  task automatic send_tok(input tok_t t, input bit with_done);
    int waits = 0;
    while (bus.in_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    chk("in_ready_before_token", 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_is_copy = t.is_copy;
    bus.in_length  = t.len;
    bus.in_offset  = t.off;
    bus.in_literal = t.lit;
    bus.done       = with_done;
    grp_q.push_back(t);
    @(negedge clk);
    idle_inputs();
    if (grp_q.size() == G || with_done) begin
      close_group(with_done);
      chk("ctrl_latency_out_valid", 32'(bus.out_valid), 32'd1);
    end else begin
      chk("fill_out_valid_low", 32'(bus.out_valid), 32'd0);
    end
  endtask

  task automatic send_done();
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    if (grp_q.size() > 0) begin
      close_group(1'b1);
      chk("flush_latency_out_valid", 32'(bus.out_valid), 32'd1);
    end else begin
      chk("empty_flush_done_pulse", 32'(bus.flush_done), 32'd1);
      chk("empty_flush_no_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("empty_flush_done_drop", 32'(bus.flush_done), 32'd0);
      chk("empty_flush_no_valid2", 32'(bus.out_valid), 32'd0);
    end
  endtask

  // ---------------- scoreboard / collector ----------------
  task automatic collect(input bit stall, input int max_bytes, input bit inject_done);
    int budget = 0;
    int taken  = 0;
    while (exp_q.size() > 0 && taken < max_bytes && budget < 1000) begin
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.done      = inject_done && (budget == 0);
      chk("in_ready_low_emit", 32'(bus.in_ready), 32'd0);
      chk("out_valid_emit", 32'(bus.out_valid), 32'd1);
      chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
      chk("out_last", 32'(bus.out_last), 32'(exp_final && exp_q.size() == 1));
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        model_bytes++;
        taken++;
      end
      @(negedge clk);
      bus.done = 1'b0;
      budget++;
    end
    if (taken < max_bytes) begin
      chk("collect_complete", 32'(exp_q.size()), 32'd0);
      chk("out_valid_after_group", 32'(bus.out_valid), 32'd0);
      chk("byte_count", bus.byte_count, 32'(model_bytes));
      if (exp_final) begin
        chk("flush_done_pulse", 32'(bus.flush_done), 32'd1);
        @(negedge clk);
        chk("flush_done_drop", 32'(bus.flush_done), 32'd0);
        chk("in_ready_after_flush", 32'(bus.in_ready), 32'd1);
      end else if (inject_done) begin
        chk("pend_wait_fill", 32'(bus.flush_done), 32'd0);
        @(negedge clk);
        chk("pend_flush_done", 32'(bus.flush_done), 32'd1);
        @(negedge clk);
        chk("pend_flush_drop", 32'(bus.flush_done), 32'd0);
      end else begin
        chk("in_ready_after_group", 32'(bus.in_ready), 32'd1);
        chk("no_flush_done", 32'(bus.flush_done), 32'd0);
      end
    end
  endtask

  task automatic alt_group(input bit stall);
    for (int i = 0; i < G; i++) begin
      if (i % 2 == 0) send_tok(copy_tok(4'd3, 12'h123), 1'b0);
      else            send_tok(lit_tok(8'hAA), 1'b0);
    end
    chk("alt_ctrl0", 32'(exp_q[0]), 32'h55);
    chk("alt_len", 32'(exp_q.size()), 32'd26);
    collect(stall, 1000, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    model_bytes = 0;
    exp_final = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
    chk("rst_byte_count", bus.byte_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 16 literals 0x00..0x0F
    for (int i = 0; i < G; i++) send_tok(lit_tok(8'(i)), 1'b0);
    chk("lit_len", 32'(exp_q.size()), 32'd18);
    collect(1'b0, 1000, 1'b0);
    chk("lit_byte_count", bus.byte_count, 32'd18);

    // alternating copy/literal, free-flowing then stalled output
    alt_group(1'b0);
    alt_group(1'b1);

    // partial group closed by separate done
    send_tok(lit_tok(8'h41), 1'b0);
    send_tok(lit_tok(8'h42), 1'b0);
    send_tok(lit_tok(8'h43), 1'b0);
    send_done();
    chk("partial_len", 32'(exp_q.size()), 32'd5);
    collect(1'b0, 1000, 1'b0);

    // empty flush
    send_done();

    // token accepted with done joins the flushed group
    send_tok(copy_tok(4'hF, 12'hABC), 1'b0);
    send_tok(lit_tok(8'h5A), 1'b1);
    collect(1'b1, 1000, 1'b0);

    // done during emission of a full group becomes a pending flush
    for (int i = 0; i < G; i++) send_tok(lit_tok(8'(8'h80 + i)), 1'b0);
    collect(1'b0, 1000, 1'b1);

    // reset in the middle of the data bytes
    for (int i = 0; i < G; i++) send_tok(lit_tok(8'(8'h30 + i)), 1'b0);
    collect(1'b0, 5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    grp_q.delete();
    model_bytes = 0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_byte_count", bus.byte_count, 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send_tok(lit_tok(8'h41), 1'b0);
    send_tok(lit_tok(8'h42), 1'b0);
    send_tok(lit_tok(8'h43), 1'b0);
    send_done();
    collect(1'b0, 1000, 1'b0);
    chk("post_rst_byte_count", bus.byte_count, 32'd5);

    // random groups
    for (int g = 0; g < 8; g++) begin
      n = $urandom_range(1, G);
      for (int i = 0; i < n; i++) begin
        send_tok(rand_tok(), (i == n - 1) && (n < G) && (g % 2 == 0));
      end
      if (n < G && (g % 2 == 1)) send_done();
      collect(1'($urandom_range(0, 1)), 1000, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
